// File: rtl/dial_zero_counter.sv
// Dial-rotation engine: restoring divider splits each rotation into full turns and a remainder.
// Define DIAL_COUNT_SAT_EN to make hits/landings saturate and raise the sticky ovf flag.
module dial_zero_counter #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIAL_SIZE   = 100,
  parameter int DIAL_START  = 50,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_dir,
  input  logic [DATA_WIDTH-1:0]        in_rot,
  input  logic                         in_last,
  output logic [$clog2(DIAL_SIZE)-1:0] pos,
  output logic [COUNT_WIDTH-1:0]       hits,
  output logic [COUNT_WIDTH-1:0]       landings,
  output logic                         upd_valid,
  output logic                         done,
  output logic                         ovf
);

  localparam int PW   = $clog2(DIAL_SIZE);
  localparam int CW   = COUNT_WIDTH;
  localparam int QW   = (DATA_WIDTH > COUNT_WIDTH) ? DATA_WIDTH : COUNT_WIDTH;
  localparam int CNTW = $clog2(DATA_WIDTH);
  localparam logic [CNTW-1:0]     CNT_LAST = CNTW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH:0] DS_D     = (DATA_WIDTH + 1)'(DIAL_SIZE);
  localparam logic [PW:0]         DS_P     = (PW + 1)'(DIAL_SIZE);
`ifdef DIAL_COUNT_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DIV, UPD} state_t;

  // Sum is wide enough to hold an untruncated quotient, so saturation sees the true total.
  function automatic logic [QW:0] wide_add(input logic [CW-1:0] acc, input logic [QW-1:0] inc,
                                           input logic bump);
    return (QW + 1)'(acc) + (QW + 1)'(inc) + (QW + 1)'(bump);
  endfunction

  function automatic logic exceeds(input logic [QW:0] w);
    return |(w >> CW);
  endfunction

  function automatic logic [CW-1:0] saturate(input logic [QW:0] w);
    return (SAT_ON && exceeds(w)) ? {CW{1'b1}} : w[CW-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic                    dir_q, dir_d, last_q, last_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [CW-1:0]           hits_q, hits_d, land_q, land_d;
  logic                    upd_q, upd_d, done_q, done_d, ovf_q, ovf_d;
  logic                    accept;
  logic [DATA_WIDTH:0]     trial;
  logic                    trial_ge;
  logic [PW:0]             pos_x, r_x, sum_r;
  logic [PW-1:0]           new_pos;
  logic                    hit_b;
  logic [QW:0]             hits_w, land_w;

  always_comb begin : datapath
    trial    = {rem_q, quo_q[DATA_WIDTH-1]};
    trial_ge = trial >= DS_D;
    pos_x    = {1'b0, pos_q};
    r_x      = {1'b0, rem_q[PW-1:0]};
    sum_r    = pos_x + r_x;
    if (dir_q) begin
      new_pos = PW'((r_x > pos_x) ? pos_x + DS_P - r_x : pos_x - r_x);
      hit_b   = (pos_q != '0) && (r_x >= pos_x);
    end else begin
      new_pos = PW'((sum_r >= DS_P) ? sum_r - DS_P : sum_r);
      hit_b   = sum_r >= DS_P;
    end
    hits_w = wide_add(hits_q, QW'(quo_q), hit_b);
    land_w = wide_add(land_q, '0, new_pos == '0);
  end

  always_comb begin : fsm
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dir_d    = dir_q;
    last_d   = last_q;
    pos_d    = pos_q;
    hits_d   = hits_q;
    land_d   = land_q;
    upd_d    = 1'b0;
    done_d   = done_q;
    ovf_d    = ovf_q;
    in_ready = (state_q == IDLE) && !done_q;
    accept   = in_valid && in_ready;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DIV;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = in_rot;
          dir_d   = in_dir;
          last_d  = in_last;
        end
      end
      DIV: begin
        cnt_d = cnt_q + CNTW'(1);
        rem_d = trial_ge ? DATA_WIDTH'(trial - DS_D) : trial[DATA_WIDTH-1:0];
        quo_d = {quo_q[DATA_WIDTH-2:0], trial_ge};
        if (cnt_q == CNT_LAST) state_d = UPD;
      end
      UPD: begin
        state_d = IDLE;
        pos_d   = new_pos;
        hits_d  = saturate(hits_w);
        land_d  = saturate(land_w);
        upd_d   = 1'b1;
        done_d  = done_q | last_q;
        ovf_d   = ovf_q | (SAT_ON && (exceeds(hits_w) || exceeds(land_w)));
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over any transition and drops a rotation in flight.
    if (clear) begin
      state_d = IDLE;
      pos_d   = PW'(DIAL_START);
      hits_d  = '0;
      land_d  = '0;
      upd_d   = 1'b0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= PW'(DIAL_START);
      hits_q  <= '0;
      land_q  <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      hits_q  <= hits_d;
      land_q  <= land_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dir_q  <= dir_d;
    last_q <= last_d;
  end

  assign pos       = pos_q;
  assign hits      = hits_q;
  assign landings  = land_q;
  assign upd_valid = upd_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dial_zero_counter.sv
// Bench for dial_zero_counter: a default instance and a 4-bit-counter instance share one stimulus
// stream and are checked every cycle against a turn-counting reference model.
module tb_dial_zero_counter;
  localparam int DW = 16;
  localparam int DS = 100;
  localparam int DSTART = 50;
`ifdef DIAL_COUNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, clear, in_valid, in_dir, in_last;
  logic [15:0] in_rot;
  logic        rdy0, upd0, done0, ovf0, rdy1, upd1, done1, ovf1;
  logic [6:0]  pos0, pos1;
  logic [31:0] hits0, land0;
  logic [3:0]  hits1, land1;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dial_zero_counter #(.DATA_WIDTH(DW), .DIAL_SIZE(DS), .DIAL_START(DSTART), .COUNT_WIDTH(32)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
    .in_dir(in_dir), .in_rot(in_rot), .in_last(in_last), .pos(pos0), .hits(hits0),
    .landings(land0), .upd_valid(upd0), .done(done0), .ovf(ovf0));

  dial_zero_counter #(.DATA_WIDTH(DW), .DIAL_SIZE(DS), .DIAL_START(DSTART), .COUNT_WIDTH(4)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
    .in_dir(in_dir), .in_rot(in_rot), .in_last(in_last), .pos(pos1), .hits(hits1),
    .landings(land1), .upd_valid(upd1), .done(done1), .ovf(ovf1));

  // Reference model: whole-rotation arithmetic, result shown DW+1 edges after acceptance.
  typedef struct packed {
    int     np;
    longint hinc;
    longint linc;
  } res_t;

  int     m_pos = DSTART;
  longint m_htot = 0, m_ltot = 0;
  bit     m_done = 0, m_busy = 0, m_upd = 0, p_last = 0;
  int     m_cnt = 0;
  res_t   p_res;

  function automatic res_t rot_model(input int p, input bit left, input int rot);
    res_t r;
    if (!left) begin
      r.hinc = (p + rot) / DS;
      r.np   = (p + rot) % DS;
    end else begin
      if (p == 0)        r.hinc = rot / DS;
      else if (rot >= p) r.hinc = (rot - p) / DS + 1;
      else               r.hinc = 0;
      r.np = ((p - rot) % DS + DS) % DS;
    end
    r.linc = (r.np == 0) ? 1 : 0;
    return r;
  endfunction

  function automatic longint exp_cnt(input longint tot, input int cw);
    longint mx;
    mx = (longint'(1) << cw) - 1;
    if (SAT) return (tot > mx) ? mx : tot;
    return tot & mx;
  endfunction

  function automatic longint exp_ovf(input int cw);
    longint mx;
    mx = (longint'(1) << cw) - 1;
    return (SAT && (m_htot > mx || m_ltot > mx)) ? 1 : 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset || clear) begin
      m_pos <= DSTART; m_htot <= 0; m_ltot <= 0;
      m_done <= 0; m_busy <= 0; m_upd <= 0; m_cnt <= 0;
    end else begin
      m_upd <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_upd  <= 1'b1;
          m_pos  <= p_res.np;
          m_htot <= m_htot + p_res.hinc;
          m_ltot <= m_ltot + p_res.linc;
          if (p_last) m_done <= 1'b1;
        end
      end else if (in_valid && !m_done) begin
        m_busy <= 1'b1;
        m_cnt  <= DW + 1;
        p_res  <= rot_model(m_pos, in_dir, int'(in_rot));
        p_last <= in_last;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("pos0", pos0, m_pos);
      chk("hits0", hits0, exp_cnt(m_htot, 32));
      chk("land0", land0, exp_cnt(m_ltot, 32));
      chk("upd0", upd0, m_upd);
      chk("rdy0", rdy0, !m_busy && !m_done);
      chk("done0", done0, m_done);
      chk("ovf0", ovf0, exp_ovf(32));
      chk("pos1", pos1, m_pos);
      chk("hits1", hits1, exp_cnt(m_htot, 4));
      chk("land1", land1, exp_cnt(m_ltot, 4));
      chk("upd1", upd1, m_upd);
      chk("rdy1", rdy1, !m_busy && !m_done);
      chk("ovf1", ovf1, exp_ovf(4));
    end
  end

  task automatic pin(input string name, input int p, input longint h, input longint l);
    chk({name, "_model_pos"}, m_pos, p);
    chk({name, "_model_hits"}, m_htot, h);
    chk({name, "_model_land"}, m_ltot, l);
    chk({name, "_pos"}, pos0, p);
    chk({name, "_hits"}, hits0, h);
    chk({name, "_land"}, land0, l);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic rotate(input bit left, input int rot, input bit last, output int lat);
    int n;
    n = 0;
    while ((m_busy || m_done) && n < 200) begin n++; @(negedge clock); end
    if (n >= 200) chk("wait_ready_timeout", n, 0);
    in_valid = 1'b1; in_dir = left; in_rot = 16'(rot); in_last = last;
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (m_busy && n < 200) begin n++; @(negedge clock); end
    if (n >= 200) chk("update_timeout", n, 0);
    lat = n;
  endtask

  initial begin
    int lat;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_dir = 1'b0; in_rot = '0; in_last = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pin("reset", 50, 0, 0);
    chk("reset_rdy", rdy0, 1);
    chk("reset_done", done0, 0);
    chk("reset_ovf", ovf0, 0);
    chk("reset_upd", upd0, 0);

    rotate(1'b0, 50, 1'b0, lat);
    chk("r50_busy_cycles", lat, 17);
    chk("r50_upd", upd0, 1);
    chk("r50_rdy", rdy0, 1);
    pin("r50", 0, 1, 1);

    do_clear();
    rotate(1'b1, 68, 1'b0, lat); pin("l68", 82, 1, 0);
    rotate(1'b1, 30, 1'b0, lat); pin("l30", 52, 1, 0);
    rotate(1'b0, 48, 1'b0, lat); pin("r48", 0, 2, 1);

    do_clear();
    rotate(1'b0, 1000, 1'b0, lat); pin("r1000", 50, 10, 0);
    rotate(1'b0, 0, 1'b0, lat);
    chk("r0_upd", upd0, 1);
    pin("r0", 50, 10, 0);

    do_clear();
    rotate(1'b0, 50, 1'b0, lat);  pin("r50b", 0, 1, 1);
    rotate(1'b1, 100, 1'b0, lat); pin("l100", 0, 2, 2);
    rotate(1'b1, 5, 1'b0, lat);   pin("l5", 95, 2, 2);

    do_clear();
    rotate(1'b0, 65535, 1'b0, lat); pin("rmax", 85, 655, 0);
    rotate(1'b1, 65535, 1'b0, lat); pin("lmax", 50, 1310, 0);

    do_clear();
    rotate(1'b0, 1600, 1'b0, lat);
    pin("r1600", 50, 16, 0);
    chk("r1600_cw4_hits", hits1, SAT ? 15 : 0);
    chk("r1600_cw4_ovf", ovf1, SAT ? 1 : 0);
    chk("r1600_ovf0", ovf0, 0);

    do_clear();
    in_valid = 1'b1; in_dir = 1'b0; in_rot = 16'd1000; in_last = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (25) @(negedge clock);
    pin("abort", 50, 0, 0);
    chk("abort_done", done0, 0);

    rotate(1'b0, 1000, 1'b1, lat);
    pin("last", 50, 10, 0);
    chk("last_done", done0, 1);
    chk("last_rdy", rdy0, 0);
    in_valid = 1'b1; in_rot = 16'd50;
    repeat (30) @(negedge clock);
    in_valid = 1'b0;
    pin("after_done", 50, 10, 0);
    chk("after_done_rdy", rdy0, 0);

    do_clear();
    chk("reclear_rdy", rdy0, 1);
    chk("reclear_done", done0, 0);
    pin("reclear", 50, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
